// File: rtl/fp_pkg.sv
// Shared floating-point library package.
// Holds the exponent-bias helper, the packed field layout of the default
// single-precision library float, and a helper that splits raw bits into
// that layout. The integer/float converters all import this package.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  // Default library float: {sign, biased exponent, stored fraction}.
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] frac;
  } fp32_t;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // View raw float bits as named fields.
  function automatic fp32_t fp_split(input logic [FP_EXP_W+FP_MANT_W:0] bits);
    return fp32_t'(bits);
  endfunction

endpackage

// File: rtl/fp_lzd.sv
// Parameterised leading-one detector (priority encoder).
// Ports:
//   i_vec  : W-bit input vector
//   o_pos  : index of the highest set bit of i_vec (0 when i_vec is zero)
//   o_zero : high when i_vec has no bits set
module fp_lzd #(
  parameter  int W  = 24,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_pos,
  output logic          o_zero
);

  // Ascending scan: the last set bit seen wins, giving the highest index.
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_pos = IW'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/fp_i2f.sv
// Pipelined signed-integer to floating-point converter (three stages).
// Converts a (MANT+1)-bit two's-complement integer into the library float
// format {sign, exp, frac}: no denormals, no NaN/inf, exact (no rounding).
// Ports:
//   clock          : sole clock, rising edge
//   clock_areset_n : asynchronous active-low reset
//   dataa          : signed integer input
//   data_valid     : dataa is valid this cycle
//   data_ready     : converter accepts dataa this cycle
//   result         : float output {sign, exp, frac}
//   result_valid   : result holds a valid conversion
//   result_ready   : downstream accepts result this cycle
module fp_i2f
  import fp_pkg::*;
#(
  parameter  int EXP   = 8,
  parameter  int MANT  = 23,
  localparam int WIDTH = 1 + EXP + MANT
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic signed [MANT:0]    dataa,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic        [WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam int BIAS = fp_bias(EXP);
  localparam int PW   = (MANT + 1 > 1) ? $clog2(MANT + 1) : 1;

  // The largest exponent produced is BIAS+MANT; it must fit the field.
  if (BIAS + MANT >= (1 << EXP)) begin : g_exp_range_check
    $error("fp_i2f: BIAS+MANT does not fit in EXP bits");
  end

  function automatic logic [WIDTH-1:0] pack_float(
    input logic            sign,
    input logic [EXP-1:0]  exp,
    input logic [MANT-1:0] frac,
    input logic            zero
  );
    // Zero is emitted as all-zero bits so no negative zero can appear.
    return zero ? '0 : {sign, exp, frac};
  endfunction

  logic                  w_advance;
  logic signed [MANT:0]  w_neg;
  logic        [MANT:0]  w_mag;
  logic        [PW-1:0]  w_pos;
  logic                  w_zero;
  logic        [PW-1:0]  w_shamt;
  logic        [MANT-1:0] w_frac;
  logic        [EXP-1:0] w_exp;

  logic                  r_vld_p0, r_vld_p1, r_vld_p2;
  logic                  r_sign_p0, r_sign_p1;
  logic        [MANT:0]  r_mag_p0;
  logic        [MANT-1:0] r_mag_p1;
  logic        [PW-1:0]  r_pos_p1;
  logic                  r_zero_p1;
  logic        [WIDTH-1:0] r_result_p2;

  // Single global enable: the whole pipeline moves unless the output is stalled.
  assign w_advance    = ~r_vld_p2 | result_ready;
  assign data_ready   = w_advance;
  assign result_valid = r_vld_p2;
  assign result       = r_result_p2;

  // ---- stage 1: sign / magnitude ----
  // -(-2^MANT) wraps back to 2^MANT, which read as unsigned is the correct magnitude.
  assign w_neg = -dataa;
  assign w_mag = dataa[MANT] ? $unsigned(w_neg) : $unsigned(dataa);

  // ---- stage 2: leading-one detect ----
  fp_lzd #(.W(MANT + 1)) u_lzd (
    .i_vec  (r_mag_p0),
    .o_pos  (w_pos),
    .o_zero (w_zero)
  );

  // ---- stage 3: normalise / pack ----
  // Only the bits below the leading one survive into the fraction, so the
  // magnitude's top bit is not carried past stage 2.
  assign w_shamt = PW'(MANT) - r_pos_p1;
  assign w_frac  = r_mag_p1 << w_shamt;
  assign w_exp   = EXP'(BIAS) + EXP'(r_pos_p1);

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
    end else if (w_advance) begin
      r_vld_p0    <= data_valid;
      r_vld_p1    <= r_vld_p0;
      r_vld_p2    <= r_vld_p1;
      r_result_p2 <= pack_float(r_sign_p1, w_exp, w_frac, r_zero_p1);
    end
  end

  // Data registers carry no reset; the valid flags qualify them.
  always_ff @(posedge clock) begin
    if (w_advance) begin
      r_sign_p0 <= dataa[MANT];
      r_mag_p0  <= w_mag;
      r_sign_p1 <= r_sign_p0;
      r_mag_p1  <= r_mag_p0[MANT-1:0];
      r_pos_p1  <= w_pos;
      // Magnitude is zero exactly when the input is zero.
      r_zero_p1 <= w_zero;
    end
  end

endmodule
